// File: rtl/clock_monitor.sv
// clock_monitor: measures the high and low phase widths of an asynchronous
// monitored clock in CLK cycles, flags widths outside programmed bounds and
// flags a clock that stops toggling.
//
// Ports:
//   CLK        system clock, all state on its rising edge
//   RST        synchronous active-high reset
//   MON_CLK    monitored clock, asynchronous to CLK
//   EN         monitor enable; dropping it returns the block to IDLE
//   CLR_ERR    clears WIDTH_ERR and STUCK (a same-cycle set wins)
//   HIGH_WIDTH last measured high width
//   LOW_WIDTH  last measured low width
//   MEAS_VALID one-cycle pulse when HIGH_WIDTH/LOW_WIDTH update
//   WIDTH_ERR  sticky, a measured width was out of bounds
//   STUCK      sticky, no MON_CLK edge within TIMEOUT cycles
module clock_monitor #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned MIN_HIGH  = 2,
    parameter int unsigned MAX_HIGH  = 1000,
    parameter int unsigned MIN_LOW   = 2,
    parameter int unsigned MAX_LOW   = 1000,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MON_CLK,
    input  logic                 EN,
    input  logic                 CLR_ERR,
    output logic [CNT_WIDTH-1:0] HIGH_WIDTH,
    output logic [CNT_WIDTH-1:0] LOW_WIDTH,
    output logic                 MEAS_VALID,
    output logic                 WIDTH_ERR,
    output logic                 STUCK
);

    localparam logic [CNT_WIDTH-1:0] MIN_HIGH_C = CNT_WIDTH'(MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0] MAX_HIGH_C = CNT_WIDTH'(MAX_HIGH);
    localparam logic [CNT_WIDTH-1:0] MIN_LOW_C  = CNT_WIDTH'(MIN_LOW);
    localparam logic [CNT_WIDTH-1:0] MAX_LOW_C  = CNT_WIDTH'(MAX_LOW);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 s1;
    logic                 s2;
    logic                 d;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] counter_n;
    logic [CNT_WIDTH-1:0] hi_hold;
    logic [CNT_WIDTH-1:0] hi_hold_n;
    logic [CNT_WIDTH-1:0] high_width_n;
    logic [CNT_WIDTH-1:0] low_width_n;
    logic                 meas_valid_n;
    logic                 width_err_n;
    logic                 stuck_n;
    logic                 set_width_err_c;
    logic                 set_stuck_c;
    logic                 rise_c;
    logic                 fall_c;
    logic                 timeout_c;
    logic                 bad_width_c;

    // Two-flop synchronizer plus history flop; runs regardless of EN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= MON_CLK;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign rise_c = s2 & ~d;
    assign fall_c = ~s2 & d;

    // State, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            counter    <= '0;
            hi_hold    <= '0;
            HIGH_WIDTH <= '0;
            LOW_WIDTH  <= '0;
            MEAS_VALID <= 1'b0;
            WIDTH_ERR  <= 1'b0;
            STUCK      <= 1'b0;
        end else begin
            state      <= state_n;
            counter    <= counter_n;
            hi_hold    <= hi_hold_n;
            HIGH_WIDTH <= high_width_n;
            LOW_WIDTH  <= low_width_n;
            MEAS_VALID <= meas_valid_n;
            WIDTH_ERR  <= width_err_n;
            STUCK      <= stuck_n;
        end
    end

    // Next-state, counter and measurement logic.
    always_comb begin
        state_n         = state;
        counter_n       = counter;
        hi_hold_n       = hi_hold;
        high_width_n    = HIGH_WIDTH;
        low_width_n     = LOW_WIDTH;
        meas_valid_n    = 1'b0;
        set_width_err_c = 1'b0;
        set_stuck_c     = 1'b0;
        timeout_c       = (counter == TIMEOUT_C);
        // In LOW, counter is the low width of the phase closing on this rise.
        bad_width_c     = (hi_hold < MIN_HIGH_C) || (hi_hold > MAX_HIGH_C) ||
                          (counter < MIN_LOW_C)  || (counter > MAX_LOW_C);

        if (!EN) begin
            state_n   = ST_IDLE;
            counter_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n   = ST_ARM;
                    counter_n = ONE_C;
                end
                ST_ARM: begin
                    if (rise_c) begin
                        state_n   = ST_HIGH;
                        counter_n = ONE_C;
                    end else if (timeout_c) begin
                        set_stuck_c = 1'b1;
                        counter_n   = ONE_C;
                    end else begin
                        counter_n = counter + ONE_C;
                    end
                end
                ST_HIGH: begin
                    if (fall_c) begin
                        hi_hold_n = counter;
                        counter_n = ONE_C;
                        state_n   = ST_LOW;
                    end else if (timeout_c) begin
                        set_stuck_c = 1'b1;
                        state_n     = ST_ARM;
                        counter_n   = ONE_C;
                    end else begin
                        counter_n = counter + ONE_C;
                    end
                end
                ST_LOW: begin
                    if (rise_c) begin
                        high_width_n    = hi_hold;
                        low_width_n     = counter;
                        meas_valid_n    = 1'b1;
                        set_width_err_c = bad_width_c;
                        counter_n       = ONE_C;
                        state_n         = ST_HIGH;
                    end else if (timeout_c) begin
                        set_stuck_c = 1'b1;
                        state_n     = ST_ARM;
                        counter_n   = ONE_C;
                    end else begin
                        counter_n = counter + ONE_C;
                    end
                end
                default: begin
                    state_n   = ST_IDLE;
                    counter_n = '0;
                end
            endcase
        end

        // Sticky flags: a set in the same cycle overrides the clear.
        width_err_n = set_width_err_c | (WIDTH_ERR & ~CLR_ERR);
        stuck_n     = set_stuck_c     | (STUCK     & ~CLR_ERR);
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Testbench for clock_monitor: directed and randomized MON_CLK patterns,
// compared every cycle against a timestamp-based reference model.
module tb_clock_monitor;

    localparam int unsigned CW         = 16;
    localparam int unsigned P_MIN_HIGH = 4;
    localparam int unsigned P_MAX_HIGH = 60;
    localparam int unsigned P_MIN_LOW  = 2;
    localparam int unsigned P_MAX_LOW  = 60;
    localparam int unsigned P_TIMEOUT  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mon = 1'b0;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] high_width;
    logic [CW-1:0] low_width;
    logic          meas_valid;
    logic          width_err;
    logic          stuck;

    int vectors     = 0;
    int miscompares = 0;

    clock_monitor #(
        .CNT_WIDTH (CW),
        .MIN_HIGH  (P_MIN_HIGH),
        .MAX_HIGH  (P_MAX_HIGH),
        .MIN_LOW   (P_MIN_LOW),
        .MAX_LOW   (P_MAX_LOW),
        .TIMEOUT   (P_TIMEOUT)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .MON_CLK    (mon),
        .EN         (en),
        .CLR_ERR    (clr),
        .HIGH_WIDTH (high_width),
        .LOW_WIDTH  (low_width),
        .MEAS_VALID (meas_valid),
        .WIDTH_ERR  (width_err),
        .STUCK      (stuck)
    );

    always #5 clk = ~clk;

    // Reference model: edges are timestamped in CLK cycles; widths are
    // differences of timestamps, STUCK is the age of the last accepted edge.
    bit          m1, m2, m3;
    bit          armed;
    bit          got_rise;
    bit          got_fall;
    int          now;
    int          anchor;
    int          t_rise;
    int          t_fall;
    logic [CW-1:0] exp_hw;
    logic [CW-1:0] exp_lw;
    bit          exp_mv;
    bit          exp_we;
    bit          exp_st;

    task automatic model_edge();
        bit rise, fall, want_rise, edge_seen, set_w, set_s;
        int hw, lw;
        set_w  = 1'b0;
        set_s  = 1'b0;
        exp_mv = 1'b0;
        if (rst) begin
            m1 = 0; m2 = 0; m3 = 0;
            armed = 0; got_rise = 0; got_fall = 0;
            exp_hw = '0; exp_lw = '0; exp_we = 0; exp_st = 0;
        end else begin
            rise = m2 & ~m3;
            fall = ~m2 & m3;
            if (!en) begin
                armed = 0;
            end else if (!armed) begin
                armed = 1; anchor = now; got_rise = 0; got_fall = 0;
            end else begin
                want_rise = !got_rise || got_fall;
                edge_seen = want_rise ? rise : fall;
                if (edge_seen) begin
                    if (want_rise) begin
                        if (got_fall) begin
                            hw     = t_fall - t_rise;
                            lw     = now - t_fall;
                            exp_hw = CW'(hw);
                            exp_lw = CW'(lw);
                            exp_mv = 1'b1;
                            set_w  = (hw < int'(P_MIN_HIGH)) || (hw > int'(P_MAX_HIGH)) ||
                                     (lw < int'(P_MIN_LOW))  || (lw > int'(P_MAX_LOW));
                        end
                        got_rise = 1; got_fall = 0; t_rise = now;
                    end else begin
                        got_fall = 1; t_fall = now;
                    end
                    anchor = now;
                end else if (now - anchor == int'(P_TIMEOUT)) begin
                    set_s = 1; anchor = now; got_rise = 0; got_fall = 0;
                end
            end
            exp_we = set_w ? 1'b1 : (clr ? 1'b0 : exp_we);
            exp_st = set_s ? 1'b1 : (clr ? 1'b0 : exp_st);
            m3 = m2; m2 = m1; m1 = mon;
        end
        now++;
    endtask

    task automatic check_outputs();
        vectors++;
        assert (high_width === exp_hw) else begin
            miscompares++;
            $error("FAIL high_width cyc %0d: got %0d want %0d", now, high_width, exp_hw);
        end
        assert (low_width === exp_lw) else begin
            miscompares++;
            $error("FAIL low_width cyc %0d: got %0d want %0d", now, low_width, exp_lw);
        end
        assert (meas_valid === exp_mv) else begin
            miscompares++;
            $error("FAIL meas_valid cyc %0d: got %b want %b", now, meas_valid, exp_mv);
        end
        assert (width_err === exp_we) else begin
            miscompares++;
            $error("FAIL width_err cyc %0d: got %b want %b", now, width_err, exp_we);
        end
        assert (stuck === exp_st) else begin
            miscompares++;
            $error("FAIL stuck cyc %0d: got %b want %b", now, stuck, exp_st);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_mon(input int high, input int low, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < high; i++) begin mon = 1'b1; tick(); end
            for (int i = 0; i < low;  i++) begin mon = 1'b0; tick(); end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        // Reset held while MON_CLK toggles.
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        for (int i = 0; i < 3; i++) begin mon = ~mon; tick(); end
        rst = 1'b0;

        // Disabled: no measurements whatever MON_CLK does.
        for (int i = 0; i < 40; i++) begin mon = 1'($urandom_range(0, 1)); tick(); end

        // Nominal 8/24 clock.
        mon = 1'b0; en = 1'b1;
        run_mon(8, 24, 4);

        // High phase below MIN_HIGH, clear, re-set, then clean clock after clear.
        run_mon(3, 24, 2);
        pulse_clr();
        run_mon(3, 24, 2);
        pulse_clr();
        run_mon(8, 24, 3);

        // Stuck high after one rise, then restart the clock.
        mon = 1'b1;
        for (int i = 0; i < 160; i++) tick();
        run_mon(8, 24, 3);
        pulse_clr();

        // Edges landing exactly on the timeout count.
        run_mon(P_TIMEOUT, 10, 2);
        run_mon(10, P_TIMEOUT, 2);
        run_mon(12, P_TIMEOUT + 20, 1);
        pulse_clr();
        run_mon(8, 24, 2);

        // Drop EN in the low phase, re-enable.
        mon = 1'b1; for (int i = 0; i < 8; i++) tick();
        mon = 1'b0; for (int i = 0; i < 10; i++) tick();
        en = 1'b0;
        run_mon(8, 24, 1);
        en = 1'b1;
        run_mon(8, 24, 3);

        // Reset in the middle of a high phase.
        mon = 1'b1; for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        run_mon(8, 24, 3);

        // Randomized clocks with occasional clears and enable drops.
        for (int s = 0; s < 14; s++) begin
            if ($urandom_range(0, 3) == 0) pulse_clr();
            if ($urandom_range(0, 5) == 0) begin en = 1'b0; tick(); tick(); en = 1'b1; end
            run_mon(int'($urandom_range(1, 70)), int'($urandom_range(1, 70)),
                    int'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 300; i++) begin
            mon = ($urandom_range(0, 3) == 0) ? ~mon : mon;
            clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
